// File: rtl/mux_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl_if
//
// Groups the scan-request, mux-sampling and snapshot handshake signals of
// mux_scan_ctrl into one bundle.
//
//   start       request a scan (honoured only while idle)
//   continuous  1 = restart at channel 0 after channel 3
//   mux_out     output of the downstream 4:1 mux
//   sel1/sel0   mux select MSB/LSB
//   busy        frame in progress
//   data        last completed snapshot, data[k] = sample of channel k
//   data_valid  snapshot available, held until acknowledged
//   data_ack    consumer acknowledges data
//   overrun     sticky: a snapshot was overwritten before being acknowledged
//
// slave  : the scan controller side
// master : the side that requests scans, feeds mux_out and consumes data
// ---------------------------------------------------------------------------
interface mux_scan_ctrl_if;
  logic       start;
  logic       continuous;
  logic       mux_out;
  logic       sel1;
  logic       sel0;
  logic       busy;
  logic [3:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       overrun;

  modport slave (
    input  start, continuous, mux_out, data_ack,
    output sel1, sel0, busy, data, data_valid, overrun
  );

  modport master (
    output start, continuous, mux_out, data_ack,
    input  sel1, sel0, busy, data, data_valid, overrun
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//
// Round-robin scan controller for a 4:1 mux. Steps the mux select through
// channels 0..3, dwells SETTLE cycles on each, samples mux_out on the last
// dwell cycle, and publishes the four samples as a 4-bit snapshot with a
// valid/ack handshake. Single-shot or continuous (back-to-back) frames.
//
// Parameters
//   SETTLE  dwell cycles per channel, 1..16
//
// Ports
//   clk     single clock, rising edge
//   rst     synchronous, active-high reset
//   bus     mux_scan_ctrl_if.slave (see interface file for signal list)
//
// Every output is a flop or a decode of flops only; nothing is
// combinational from an input.
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_ctrl_if.slave bus
);

  // Dwell counter width: SETTLE=1 still needs a 1-bit counter so the
  // comparison below stays well formed.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          r_state;
  logic [1:0]      r_ch;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_shadow;
  logic [3:0]      r_data;
  logic            r_valid;
  logic            r_overrun;

  state_t          w_state_next;
  logic [1:0]      w_ch_next;
  logic [CW-1:0]   w_cnt_next;
  logic [2:0]      w_shadow_next;
  logic [3:0]      w_data_next;
  logic            w_valid_next;
  logic            w_overrun_next;

  logic            w_sample;      // this edge is a sampling edge
  logic            w_frame_done;  // this edge samples channel 3
  logic            w_ack_ok;      // ack arrives while a snapshot is pending
  logic [2:0]      w_cap;         // per-channel shadow capture strobes

  assign w_ack_ok = bus.data_ack && r_valid;

  // -------------------------------------------------------------------------
  // Shadow capture: channels 0..2 are parked in the shadow register until
  // channel 3 is sampled, at which point the whole snapshot is published in
  // one go so data never shows a half-updated frame.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
      assign w_cap[gi]         = w_sample && (r_ch == 2'(gi));
      assign w_shadow_next[gi] = w_cap[gi] ? bus.mux_out : r_shadow[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_ch_next      = r_ch;
    w_cnt_next     = r_cnt;
    w_data_next    = r_data;
    w_valid_next   = r_valid;
    w_overrun_next = r_overrun;
    w_sample       = 1'b0;
    w_frame_done   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next   = SCAN;
          w_ch_next      = 2'd0;
          w_cnt_next     = '0;
          w_overrun_next = 1'b0;
        end
      end

      SCAN: begin
        if (r_cnt == CNT_LAST) begin
          w_sample   = 1'b1;
          w_cnt_next = '0;
          if (r_ch == 2'd3) begin
            w_frame_done = 1'b1;
            // Channel 3 goes straight from the mux into the snapshot.
            w_data_next  = {bus.mux_out, r_shadow};
            // Select returns to 00 on this edge in both modes.
            w_ch_next    = 2'd0;
            if (!bus.continuous) begin
              w_state_next = IDLE;
            end
          end else begin
            w_ch_next = r_ch + 2'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_ch_next    = 2'd0;
        w_cnt_next   = '0;
      end
    endcase

    // Snapshot handshake. A completion wins over a same-edge ack: the new
    // frame is pending, and since the old one was consumed there is no
    // overrun.
    if (w_frame_done) begin
      w_valid_next = 1'b1;
      if (r_valid && !bus.data_ack) begin
        w_overrun_next = 1'b1;
      end
    end else if (w_ack_ok) begin
      w_valid_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ch      <= 2'd0;
      r_cnt     <= '0;
      r_shadow  <= 3'b000;
      r_data    <= 4'b0000;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ch      <= w_ch_next;
      r_cnt     <= w_cnt_next;
      r_shadow  <= w_shadow_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_overrun <= w_overrun_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The channel index is forced to 0 whenever the controller
  // leaves SCAN, so it can drive the select lines directly.
  // -------------------------------------------------------------------------
  assign bus.sel1       = r_ch[1];
  assign bus.sel0       = r_ch[0];
  assign bus.busy       = (r_state == SCAN);
  assign bus.data       = r_data;
  assign bus.data_valid = r_valid;
  assign bus.overrun    = r_overrun;

endmodule
